// File: rtl/ysyx_24080006_counter_ctrl.sv
// Bus-side controller for a 64-bit counter: 32-bit register window, tear-free
// snapshot read of the high half, prescaled increment enable and compare interrupt.
module ysyx_24080006_counter_ctrl #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        counter_incr_en,
    output logic        counter_high_we,
    output logic        counter_low_we,
    output logic [31:0] counter_wdata,
    input  logic [31:0] counter_high_rdata,
    input  logic [31:0] counter_low_rdata,
    output logic        timer_irq
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 32'd1);
    localparam logic [2:0]  SEL_CNT_LO = 3'd0;
    localparam logic [2:0]  SEL_CNT_HI = 3'd1;
    localparam logic [2:0]  SEL_CMP_LO = 3'd2;
    localparam logic [2:0]  SEL_CMP_HI = 3'd3;
    localparam logic [2:0]  SEL_CTRL   = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        en_r;
    logic        irq_en_r;
    logic [63:0] cmp_r;
    logic        snap_valid_r;
    logic [31:0] snap_hi_r;
    logic [15:0] presc_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic        irq_r;

    logic        accept_s;
    logic        addr_ok_s;
    logic        wr_s;
    logic        rd_s;
    logic [2:0]  sel_s;
    logic [31:0] rd_data_s;
    logic [63:0] count_s;

    assign sel_s   = req_addr[4:2];
    assign count_s = {counter_high_rdata, counter_low_rdata};

    // Request decode; a request coinciding with reset is never accepted
    always_comb begin
        accept_s  = (state_r == IDLE) && req_valid && !reset;
        addr_ok_s = (req_addr[1:0] == 2'b00) && (req_addr <= 5'h10);
        wr_s      = accept_s && addr_ok_s && req_we;
        rd_s      = accept_s && addr_ok_s && !req_we;
    end

    // Read data mux; CNT_HI prefers the snapshot taken by the last CNT_LO read
    always_comb begin
        case (sel_s)
            SEL_CNT_LO: rd_data_s = counter_low_rdata;
            SEL_CNT_HI: rd_data_s = snap_valid_r ? snap_hi_r : counter_high_rdata;
            SEL_CMP_LO: rd_data_s = cmp_r[31:0];
            SEL_CMP_HI: rd_data_s = cmp_r[63:32];
            SEL_CTRL:   rd_data_s = {30'd0, irq_en_r, en_r};
            default:    rd_data_s = 32'h0000_0000;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = RESP;
                else          state_next_s = IDLE;
            end
            RESP: begin
                if (rsp_ready) state_next_s = IDLE;
                else           state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs and counter write strobes (strobes only in the accepting cycle)
    always_comb begin
        req_ready       = (state_r == IDLE);
        rsp_valid       = (state_r == RESP);
        counter_low_we  = wr_s && (sel_s == SEL_CNT_LO);
        counter_high_we = wr_s && (sel_s == SEL_CNT_HI);
        counter_wdata   = req_wdata;
    end

    assign rsp_rdata       = rdata_r;
    assign rsp_err         = err_r;
    assign timer_irq       = irq_r;
    assign counter_incr_en = en_r && (presc_r == PRESC_LAST);

    // Response registers, captured at acceptance and held through RESP
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else if (accept_s) begin
            err_r   <= !addr_ok_s;
            rdata_r <= rd_s ? rd_data_s : 32'h0000_0000;
        end
    end

    // CTRL and compare registers
    always_ff @(posedge clock) begin
        if (reset) begin
            en_r     <= 1'b0;
            irq_en_r <= 1'b0;
            cmp_r    <= {64{1'b1}};
        end else if (wr_s) begin
            case (sel_s)
                SEL_CMP_LO: cmp_r[31:0]  <= req_wdata;
                SEL_CMP_HI: cmp_r[63:32] <= req_wdata;
                SEL_CTRL: begin
                    en_r     <= req_wdata[0];
                    irq_en_r <= req_wdata[1];
                end
                default: begin
                end
            endcase
        end
    end

    // High-half snapshot: set by a CNT_LO read, consumed by CNT_HI, dropped by counter writes
    always_ff @(posedge clock) begin
        if (reset) begin
            snap_hi_r    <= 32'h0000_0000;
            snap_valid_r <= 1'b0;
        end else if (rd_s && (sel_s == SEL_CNT_LO)) begin
            snap_hi_r    <= counter_high_rdata;
            snap_valid_r <= 1'b1;
        end else if ((rd_s || wr_s) && (sel_s == SEL_CNT_HI)) begin
            snap_valid_r <= 1'b0;
        end else if (wr_s && (sel_s == SEL_CNT_LO)) begin
            snap_valid_r <= 1'b0;
        end
    end

    // Prescaler: counts 0..PRESCALE-1 while enabled, parked at 0 otherwise
    always_ff @(posedge clock) begin
        if (reset || !en_r) begin
            presc_r <= 16'd0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // Level compare interrupt, registered one cycle behind the counter
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_en_r && (count_s >= cmp_r);
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_counter_ctrl.sv
// Bench for ysyx_24080006_counter_ctrl: two instances (PRESCALE 1 and 4) each driving
// a 64-bit counter, checked every cycle against a transaction-level model plus literals.
module tb_ysyx_24080006_counter_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        incr_en   [2];
    logic        hi_we     [2];
    logic        lo_we     [2];
    logic [31:0] cnt_wdata [2];
    logic        irq       [2];
    logic [63:0] env_cnt   [2] = '{64'd0, 64'd0};

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    logic [31:0] last_rd  [2];
    logic        last_err [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_24080006_counter_ctrl #(.PRESCALE((g == 0) ? 1 : 4)) dut (
            .clock(clock), .reset(reset),
            .req_valid(req_valid), .req_ready(req_ready[g]), .req_we(req_we),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
            .counter_incr_en(incr_en[g]), .counter_high_we(hi_we[g]),
            .counter_low_we(lo_we[g]), .counter_wdata(cnt_wdata[g]),
            .counter_high_rdata(env_cnt[g][63:32]), .counter_low_rdata(env_cnt[g][31:0]),
            .timer_irq(irq[g])
        );
    end

    // The counters owned by the controllers: writes win over increments
    always @(posedge clock) begin
        for (int j = 0; j < 2; j++) begin
            if (lo_we[j] || hi_we[j]) begin
                if (lo_we[j]) env_cnt[j][31:0]  <= cnt_wdata[j];
                if (hi_we[j]) env_cnt[j][63:32] <= cnt_wdata[j];
            end else if (incr_en[j]) begin
                env_cnt[j] <= env_cnt[j] + 64'd1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic        m_busy, m_err, m_en, m_irqen, m_snap_v;
    logic [63:0] m_cmp;
    int          m_ecyc = 0;
    logic [31:0] m_rdata   [2];
    logic [31:0] m_snap_hi [2];
    logic        m_irq     [2];
    logic [63:0] m_cnt     [2] = '{64'd0, 64'd0};

    logic acc_e, ok_e, lo_we_e, hi_we_e;
    logic incr_e [2];

    function automatic int pr(input int j);
        return (j == 0) ? 1 : 4;
    endfunction

    always_comb begin
        acc_e   = !m_busy && req_valid && !reset;
        ok_e    = (req_addr[1:0] == 2'b00) && (req_addr <= 5'h10);
        lo_we_e = acc_e && req_we && (req_addr == 5'h00);
        hi_we_e = acc_e && req_we && (req_addr == 5'h04);
        for (int j = 0; j < 2; j++)
            incr_e[j] = m_en && ((m_ecyc % pr(j)) == (pr(j) - 1));
    end

    always @(posedge clock) begin
        for (int j = 0; j < 2; j++) begin
            if (lo_we_e || hi_we_e) begin
                if (lo_we_e) m_cnt[j][31:0]  <= req_wdata;
                if (hi_we_e) m_cnt[j][63:32] <= req_wdata;
            end else if (incr_e[j]) begin
                m_cnt[j] <= m_cnt[j] + 64'd1;
            end
        end
        if (reset) begin
            m_busy   <= 1'b0;
            m_err    <= 1'b0;
            m_en     <= 1'b0;
            m_irqen  <= 1'b0;
            m_snap_v <= 1'b0;
            m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_ecyc   <= 0;
            for (int j = 0; j < 2; j++) begin
                m_rdata[j]   <= 32'd0;
                m_snap_hi[j] <= 32'd0;
                m_irq[j]     <= 1'b0;
            end
        end else begin
            m_ecyc <= m_en ? m_ecyc + 1 : 0;
            for (int j = 0; j < 2; j++) m_irq[j] <= m_irqen && (m_cnt[j] >= m_cmp);
            if (acc_e) begin
                m_busy <= 1'b1;
                m_err  <= !ok_e;
                for (int j = 0; j < 2; j++) m_rdata[j] <= 32'd0;
                if (ok_e && req_we) begin
                    case (req_addr)
                        5'h00, 5'h04: m_snap_v <= 1'b0;
                        5'h08: m_cmp[31:0]  <= req_wdata;
                        5'h0C: m_cmp[63:32] <= req_wdata;
                        5'h10: begin m_en <= req_wdata[0]; m_irqen <= req_wdata[1]; end
                        default: ;
                    endcase
                end else if (ok_e) begin
                    for (int j = 0; j < 2; j++) begin
                        case (req_addr)
                            5'h00: begin m_rdata[j] <= m_cnt[j][31:0]; m_snap_hi[j] <= m_cnt[j][63:32]; end
                            5'h04: m_rdata[j] <= m_snap_v ? m_snap_hi[j] : m_cnt[j][63:32];
                            5'h08: m_rdata[j] <= m_cmp[31:0];
                            5'h0C: m_rdata[j] <= m_cmp[63:32];
                            5'h10: m_rdata[j] <= {30'd0, m_irqen, m_en};
                            default: ;
                        endcase
                    end
                    if (req_addr == 5'h00) m_snap_v <= 1'b1;
                    if (req_addr == 5'h04) m_snap_v <= 1'b0;
                end
            end else if (m_busy && rsp_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clock) begin
        #1;
        if (chk_on) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("req_ready%0d", j), 64'(req_ready[j]), 64'(!m_busy));
                chk($sformatf("rsp_valid%0d", j), 64'(rsp_valid[j]), 64'(m_busy));
                chk($sformatf("rsp_rdata%0d", j), 64'(rsp_rdata[j]), 64'(m_rdata[j]));
                chk($sformatf("rsp_err%0d", j), 64'(rsp_err[j]), 64'(m_err));
                chk($sformatf("incr_en%0d", j), 64'(incr_en[j]), 64'(incr_e[j]));
                chk($sformatf("low_we%0d", j), 64'(lo_we[j]), 64'(lo_we_e));
                chk($sformatf("high_we%0d", j), 64'(hi_we[j]), 64'(hi_we_e));
                if (lo_we_e || hi_we_e)
                    chk($sformatf("cnt_wdata%0d", j), 64'(cnt_wdata[j]), 64'(req_wdata));
                chk($sformatf("timer_irq%0d", j), 64'(irq[j]), 64'(m_irq[j]));
                chk($sformatf("counter%0d", j), env_cnt[j], m_cnt[j]);
            end
        end
    end

    // One bus transaction: accept at the next posedge, sample the response one cycle later
    task automatic xfer(input logic we, input logic [4:0] addr, input logic [31:0] wd, input bit keep);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        rsp_ready = !keep;
        @(negedge clock);
        req_valid = 1'b0;
        req_we    = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            last_rd[j]  = rsp_rdata[j];
            last_err[j] = rsp_err[j];
        end
        chk("xfer_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
        xfer(1'b1, addr, wd, 1'b0);
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] addr, input int j,
                          input logic [31:0] exp, input logic exp_err);
        xfer(1'b0, addr, 32'd0, 1'b0);
        chk(nm, 64'(last_rd[j]), 64'(exp));
        chk({nm, "_err"}, 64'(last_err[j]), 64'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 5'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        chk_on = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready[0]), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
        chk("rst_irq", 64'(irq[0]), 64'd0);
        chk("rst_incr_en", 64'(incr_en[0]), 64'd0);
        rd_chk("rst_cmp_hi", 5'h0C, 0, 32'hFFFF_FFFF, 1'b0);
        rd_chk("rst_ctrl", 5'h10, 0, 32'd0, 1'b0);

        // carry across the halves with a consistent snapshot
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h04, 32'h0000_0001);
        wr(5'h10, 32'h1);
        repeat (2) @(negedge clock);
        rd_chk("t1_lo", 5'h00, 0, 32'h0000_0001, 1'b0);
        rd_chk("t1_hi", 5'h04, 0, 32'h0000_0002, 1'b0);

        // snapshot hides the carry that happens between the two reads
        wr(5'h10, 32'h0);
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h04, 32'h0);
        wr(5'h10, 32'h1);
        rd_chk("t2_lo", 5'h00, 0, 32'hFFFF_FFFF, 1'b0);
        rd_chk("t2_hi_snap", 5'h04, 0, 32'h0000_0000, 1'b0);
        rd_chk("t2_hi_live", 5'h04, 0, 32'h0000_0001, 1'b0);

        // 40 enabled cycles: 40 increments at PRESCALE=1, 10 at PRESCALE=4
        wr(5'h10, 32'h0);
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h10, 32'h1);
        repeat (38) @(negedge clock);
        wr(5'h10, 32'h0);
        xfer(1'b0, 5'h00, 32'd0, 1'b0);
        chk("t3_lo_p1", 64'(last_rd[0]), 64'd40);
        chk("t3_lo_p4", 64'(last_rd[1]), 64'd10);
        repeat (6) @(negedge clock);
        rd_chk("t3_lo_p4_stopped", 5'h00, 1, 32'd10, 1'b0);

        // compare interrupt rises one cycle after reaching CMP, falls after raising CMP
        wr(5'h00, 32'd95);
        wr(5'h04, 32'd0);
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd100);
        wr(5'h10, 32'h3);
        repeat (5) @(negedge clock);
        #1;
        chk("t4_cnt_at_100", 64'(env_cnt[0][31:0]), 64'd100);
        chk("t4_irq_not_yet", 64'(irq[0]), 64'd0);
        @(negedge clock);
        #1;
        chk("t4_irq_rise", 64'(irq[0]), 64'd1);
        wr(5'h08, 32'd1000);
        chk("t4_irq_still", 64'(irq[0]), 64'd1);
        @(negedge clock);
        #1;
        chk("t4_irq_fall", 64'(irq[0]), 64'd0);
        wr(5'h10, 32'h0);

        // error accesses
        rd_chk("t5_rd14", 5'h14, 0, 32'd0, 1'b1);
        rd_chk("t5_rd02", 5'h02, 0, 32'd0, 1'b1);
        xfer(1'b1, 5'h1C, 32'hFFFF_FFFF, 1'b0);
        chk("t5_wr1c_err", 64'(last_err[0]), 64'd1);
        xfer(1'b1, 5'h01, 32'hDEAD_BEEF, 1'b0);
        chk("t5_wr01_err", 64'(last_err[1]), 64'd1);
        rd_chk("t5_cmp_lo", 5'h08, 0, 32'd1000, 1'b0);
        rd_chk("t5_ctrl", 5'h10, 1, 32'd0, 1'b0);

        // backpressure, then reset while a response is pending
        wr(5'h08, 32'd0);
        wr(5'h0C, 32'd0);
        wr(5'h10, 32'h3);
        repeat (2) @(negedge clock);
        #1;
        chk("t6_irq_on", 64'(irq[0]), 64'd1);
        xfer(1'b0, 5'h10, 32'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #1;
            chk("t6_hold_valid", 64'(rsp_valid[0]), 64'd1);
            chk("t6_hold_rdata", 64'(rsp_rdata[0]), 64'd3);
            chk("t6_hold_ready", 64'(req_ready[0]), 64'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h10; req_wdata = 32'h3;
        #1;
        chk("t6_rst_valid", 64'(rsp_valid[0]), 64'd0);
        chk("t6_rst_irq", 64'(irq[0]), 64'd0);
        chk("t6_rst_ready", 64'(req_ready[0]), 64'd1);
        @(negedge clock);
        req_addr = 5'h00; req_wdata = 32'h1234_5678;
        @(negedge clock);
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
        rd_chk("t6_ctrl_after", 5'h10, 0, 32'd0, 1'b0);
        rd_chk("t6_cmp_after", 5'h08, 0, 32'hFFFF_FFFF, 1'b0);
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_counter_ctrl.md
Name: ysyx_24080006_counter_ctrl

Overview:
- Bus-side controller for a 64-bit counter: owns the counter's increment and write ports and consumes its two 32-bit read halves.
- Exposes the counter to a 32-bit valid/ready register bus.
- Provides a tear-free 64-bit read through a high-half snapshot, a prescaled increment enable, and a 64-bit compare that raises a timer interrupt.
- Sits between the core's MMIO/CSR path and the counter.

Parameters:
- PRESCALE, 1, counter increments once every PRESCALE clocks while enabled; legal range 1..65535.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request valid
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  5  byte address
- req_wdata  input  32  write data
- rsp_valid  output  1  response valid
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  32  read data; 0 for writes and errors
- rsp_err  output  1  unmapped or misaligned access
- counter_incr_en  output  1  increment strobe to the counter
- counter_high_we  output  1  write strobe, counter high half
- counter_low_we  output  1  write strobe, counter low half
- counter_wdata  output  32  write data to the counter
- counter_high_rdata  input  32  counter high half
- counter_low_rdata  input  32  counter low half
- timer_irq  output  1  registered compare interrupt

Behaviour:
- Register map (word-aligned only):
  - 0x00 CNT_LO (RW)
  - 0x04 CNT_HI (RW)
  - 0x08 CMP_LO (RW)
  - 0x0C CMP_HI (RW)
  - 0x10 CTRL (RW): bit0 EN, bit1 IRQ_EN; other bits read 0 and ignore writes.
  - Every other address, or addr[1:0]!=0, is an error.
- FSM, two states: IDLE and RESP.
  - IDLE: req_ready=1. When req_valid=1 the request is accepted; all side effects take place at that clock edge; next state is RESP.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err are registered and held stable until rsp_ready=1, then the FSM returns to IDLE.
  - Latency: response 1 cycle after acceptance. Maximum throughput: one transaction every 2 cycles.
- Counter writes:
  - counter_low_we / counter_high_we are asserted combinationally only in the accepting cycle of a write to 0x00 / 0x04.
  - counter_wdata = req_wdata (don't-care otherwise).
  - The counter gives writes priority, so an increment coinciding with a write is dropped. This is intended.
- Counter reads:
  - Data is sampled from counter_*_rdata in the accepting cycle; pre-increment values are returned.
  - Reading CNT_LO returns the live low half, latches the live high half into snap_hi, and sets snap_valid.
  - Reading CNT_HI returns snap_hi if snap_valid=1 and clears snap_valid; otherwise it returns the live high half.
  - Any write to CNT_LO or CNT_HI clears snap_valid.
- Prescaler (16-bit):
  - When EN=1, it counts 0..PRESCALE-1 and pulses counter_incr_en for one cycle on the terminal count, then wraps to 0.
  - With PRESCALE=1, counter_incr_en=EN every cycle.
  - When EN=0, the prescaler is held at 0 and counter_incr_en=0.
- Compare:
  - timer_irq is registered: next = IRQ_EN & ({counter_high_rdata, counter_low_rdata} >= {CMP_HI, CMP_LO}), unsigned 64-bit.
  - timer_irq is level, not sticky; it is cleared by raising CMP or clearing IRQ_EN.
- Error access: rsp_err=1, rsp_rdata=0, no register, snapshot or counter side effects.
- Reset values:
  - State IDLE; req_ready=1 (in IDLE).
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - CTRL=0; CMP=0xFFFF_FFFF_FFFF_FFFF.
  - snap_valid=0, snap_hi=0, prescaler=0.
  - counter_incr_en=0, timer_irq=0, strobes=0.
- Reset during RESP drops the pending response. A write accepted on the same edge as reset has no effect.
- Wrap-around: the counter wraps 0xFFFF_FFFF_FFFF_FFFF→0. The controller adds no special handling; a compare against a wrapped counter simply deasserts timer_irq.

Test Plan:
- Write CNT_LO=0xFFFF_FFFE, CNT_HI=0x0000_0001, CTRL=0x1, PRESCALE=1; wait 3 cycles; read LO then HI -> LO=0x0000_0001, HI=0x0000_0002 (carry, snapshot consistent).
- Counter at 0x0000_0000_FFFF_FFFF with EN=1: read LO (returns 0xFFFF_FFFF), counter carries, then read HI -> HI=0x0000_0000 from the snapshot; a second HI read -> live value 0x0000_0001.
- PRESCALE=4, EN=1 from counter 0 for 40 cycles -> counter=10; counter_incr_en high exactly every 4th cycle; clearing EN -> no further increments and prescaler reads 0.
- CMP={0,100}, IRQ_EN=1, EN=1, counter from 95 -> timer_irq rises 1 cycle after the counter reaches 100; write CMP_LO=1000 -> timer_irq falls the cycle after the update.
- Read 0x14 and read 0x02 -> rsp_err=1, rsp_rdata=0, no counter strobes; write 0x1C -> rsp_err=1, registers unchanged.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; assert reset in RESP -> rsp_valid=0 next cycle, CTRL=0, timer_irq=0.
